// File: rtl/uart_rx_ctrl.sv
// Receive-path frame sequencer for an oversampled UART: tracks the position within
// each bit, steps START/DATA/PARITY/STOP, and drives the datapath checker enables.
module uart_rx_ctrl #(
    parameter int data_width     = 8,
    parameter int edge_cnt_width = 6,
    parameter int prescale_width = 6,
    parameter int bit_cnt_width  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [prescale_width-1:0] prescale,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic [edge_cnt_width-1:0] edge_cnt,
    output logic [bit_cnt_width-1:0]  bit_cnt,
    output logic                      dat_samp_en,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                      state_r;
    state_t                      state_s;
    logic [prescale_width-1:0]   prescale_r;
    logic                        par_en_r;
    logic [edge_cnt_width-1:0]   edge_cnt_r;
    logic [edge_cnt_width-1:0]   edge_cnt_s;
    logic [bit_cnt_width-1:0]    bit_cnt_r;
    logic [bit_cnt_width-1:0]    bit_cnt_s;
    logic [edge_cnt_width-1:0]   last_edge_s;
    logic                        bit_end_s;
    logic                        last_bit_s;
    logic                        capture_s;
    logic                        frame_ok_s;
    logic                        dat_samp_en_r;
    logic                        deser_en_r;
    logic                        strt_chk_en_r;
    logic                        par_chk_en_r;
    logic                        stp_chk_en_r;
    logic                        data_valid_r;
    logic                        busy_r;

    // Timing decode against the prescale value frozen at frame start.
    always_comb begin
        last_edge_s = edge_cnt_width'(prescale_r) - edge_cnt_width'(1);
        bit_end_s   = (state_r != IDLE) && (edge_cnt_r == last_edge_s);
        last_bit_s  = (bit_cnt_r == bit_cnt_width'(data_width - 1));
        capture_s   = (state_r == IDLE) && (RX_IN == 1'b0);
        frame_ok_s  = (state_r == STOP) && bit_end_s && (stp_err == 1'b0) &&
                      ((par_en_r == 1'b0) || (par_err == 1'b0));
    end

    // Next-state and counter logic.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        edge_cnt_s = edge_cnt_r;

        if ((state_r == IDLE) || bit_end_s) begin
            edge_cnt_s = {edge_cnt_width{1'b0}};
        end else begin
            edge_cnt_s = edge_cnt_r + edge_cnt_width'(1);
        end

        case (state_r)
            IDLE: begin
                bit_cnt_s = {bit_cnt_width{1'b0}};
                if (RX_IN == 1'b0) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                bit_cnt_s = {bit_cnt_width{1'b0}};
                if (bit_end_s) begin
                    if (strt_glitch) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (last_bit_s) begin
                        bit_cnt_s = {bit_cnt_width{1'b0}};
                        if (par_en_r) begin
                            state_s = PARITY;
                        end else begin
                            state_s = STOP;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + bit_cnt_width'(1);
                        state_s   = DATA;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r;
                    state_s   = DATA;
                end
            end
            PARITY: begin
                bit_cnt_s = {bit_cnt_width{1'b0}};
                if (bit_end_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                bit_cnt_s = {bit_cnt_width{1'b0}};
                if (bit_end_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s    = IDLE;
                bit_cnt_s  = {bit_cnt_width{1'b0}};
                edge_cnt_s = {edge_cnt_width{1'b0}};
            end
        endcase
    end

    // State, counters, frame configuration and registered decode of the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= IDLE;
            prescale_r    <= {prescale_width{1'b0}};
            par_en_r      <= 1'b0;
            edge_cnt_r    <= {edge_cnt_width{1'b0}};
            bit_cnt_r     <= {bit_cnt_width{1'b0}};
            dat_samp_en_r <= 1'b0;
            deser_en_r    <= 1'b0;
            strt_chk_en_r <= 1'b0;
            par_chk_en_r  <= 1'b0;
            stp_chk_en_r  <= 1'b0;
            data_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r    <= state_s;
            edge_cnt_r <= edge_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            if (capture_s) begin
                prescale_r <= prescale;
                par_en_r   <= PAR_EN;
            end
            // Registering the decode of state_s keeps each enable aligned with state_r.
            dat_samp_en_r <= (state_s != IDLE);
            deser_en_r    <= (state_s == DATA);
            strt_chk_en_r <= (state_s == START);
            par_chk_en_r  <= (state_s == PARITY);
            stp_chk_en_r  <= (state_s == STOP);
            busy_r        <= (state_s != IDLE);
            data_valid_r  <= frame_ok_s;
        end
    end

    assign edge_cnt    = edge_cnt_r;
    assign bit_cnt     = bit_cnt_r;
    assign dat_samp_en = dat_samp_en_r;
    assign deser_en    = deser_en_r;
    assign strt_chk_en = strt_chk_en_r;
    assign par_chk_en  = par_chk_en_r;
    assign stp_chk_en  = stp_chk_en_r;
    assign data_valid  = data_valid_r;
    assign busy        = busy_r;

endmodule
